// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: merges load-use, branch and
// data-memory handshake into per-stage enables, with a memory watchdog and perf counters.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             branch_i,
    input  logic             mem_access_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_noop_o,
    output logic             pipe_write_o,
    output logic             mem_req_o,
    output logic [1:0]       state_o,
    output logic             error_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2,
        S_ERROR   = 2'd3
    } state_e;

    localparam int unsigned         WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0]   TIMEOUT_W = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              apply_run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        apply_run    = 1'b0;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        idex_noop_o  = 1'b0;
        pipe_write_o = 1'b0;
        mem_req_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                mem_req_o = mem_access_i;
                if (mem_access_i && !mem_ready_i) begin
                    state_d = S_MEMWAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    apply_run = 1'b1;
                end
            end
            S_MEMWAIT: begin
                mem_req_o = 1'b1;
                // Completion beats the watchdog when both land in the same cycle.
                if (mem_access_i && mem_ready_i) begin
                    apply_run = 1'b1;
                    state_d   = S_RUN;
                    wait_d    = '0;
                end else begin
                    if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
                    if ((TIMEOUT != 0) && (wait_q == TIMEOUT_W)) state_d = S_ERROR;
                end
            end
            default: ;
        endcase

        // Load-use outranks branch: branch operands are not valid during a load-use stall.
        if (apply_run) begin
            if (hazard_i) begin
                idex_noop_o  = 1'b1;
                pipe_write_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                pipe_write_o = 1'b1;
                ifid_flush_o = branch_i;
            end
        end
    end

    assign state_o = state_q;
    assign error_o = (state_q == S_ERROR);

    logic       active;
    logic [2:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [3];

    assign active  = (state_q == S_RUN) || (state_q == S_MEMWAIT);
    assign cnt_inc = {ifid_flush_o, active && !pc_write_o, active};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign cycle_cnt_o = cnt_q[0];
    assign stall_cnt_o = cnt_q[1];
    assign flush_cnt_o = cnt_q[2];

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios then random traffic, every cycle
// compared against a rule-level reference model.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 5;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1, start_i = 1'b0, hazard_i = 1'b0, branch_i = 1'b0;
    logic mem_access_i = 1'b0, mem_ready_i = 1'b0;
    logic pc_write_o, ifid_write_o, ifid_flush_o, idex_noop_o, pipe_write_o, mem_req_o;
    logic [1:0] state_o;
    logic error_o;
    logic [CNT_W-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
        .branch_i(branch_i), .mem_access_i(mem_access_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_noop_o(idex_noop_o), .pipe_write_o(pipe_write_o), .mem_req_o(mem_req_o),
        .state_o(state_o), .error_o(error_o), .cycle_cnt_o(cycle_cnt_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 IDLE, 1 RUN, 2 MEMWAIT, 3 ERROR
    int m_state = 0, m_wait = 0, m_cyc = 0, m_stall = 0, m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic step(input logic r, input logic s, input logic h, input logic b,
                        input logic a, input logic y);
        bit e_pc, e_ifid, e_flush, e_noop, e_pipe, e_req, normal;
        @(negedge clk_i);
        rst_i = r; start_i = s; hazard_i = h; branch_i = b; mem_access_i = a; mem_ready_i = y;
        #1;
        e_pc = 0; e_ifid = 0; e_flush = 0; e_noop = 0; e_pipe = 0; e_req = 0; normal = 0;
        if (m_state == 1) begin
            e_req  = a;
            normal = !(a && !y);
        end else if (m_state == 2) begin
            e_req  = 1;
            normal = a && y;
        end
        if (normal) begin
            if (h) begin
                e_noop = 1; e_pipe = 1;
            end else begin
                e_pc = 1; e_ifid = 1; e_pipe = 1; e_flush = b;
            end
        end

        chk("state", 32'(state_o), 32'(m_state));
        chk("error", 32'(error_o), 32'(m_state == 3));
        chk("cycle_cnt", 32'(cycle_cnt_o), 32'(m_cyc));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
        chk("ctrl", {26'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_noop_o, pipe_write_o, mem_req_o},
            {26'd0, e_pc, e_ifid, e_flush, e_noop, e_pipe, e_req});
        $display("cyc rst=%0b st=%0b hz=%0b br=%0b acc=%0b rdy=%0b | state=%0d pc=%0b ifid=%0b fl=%0b nop=%0b pipe=%0b req=%0b cnt=%0d/%0d/%0d",
                 r, s, h, b, a, y, state_o, pc_write_o, ifid_write_o, ifid_flush_o,
                 idex_noop_o, pipe_write_o, mem_req_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o);

        if (r) begin
            m_state = 0; m_wait = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_state == 1 || m_state == 2) begin
                m_cyc = sat(m_cyc + 1);
                if (!e_pc) m_stall = sat(m_stall + 1);
            end
            if (e_flush) m_flush = sat(m_flush + 1);
            case (m_state)
                0: if (s) m_state = 1;
                1: if (a && !y) begin m_state = 2; m_wait = 1; end
                2: if (a && y) begin
                        m_state = 1; m_wait = 0;
                    end else begin
                        if (TIMEOUT != 0 && m_wait == TIMEOUT) m_state = 3;
                        m_wait = m_wait + 1;
                    end
                default: ;
            endcase
        end
    endtask

    task automatic after_edge_chk(input string tag, input logic [31:0] got_now_sel, input logic [31:0] exp);
        chk(tag, got_now_sel, exp);
    endtask

    initial begin
        // Reset and start-up
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("start_to_run", 32'(state_o), 32'd1);
        chk("counters_zero", 32'(cycle_cnt_o), 32'd0);

        // Load-use, branch, branch+hazard
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        @(posedge clk_i); #1;
        chk("stall_after_hazards", 32'(stall_cnt_o), 32'd2);
        chk("flush_once", 32'(flush_cnt_o), 32'd1);

        // Memory wait: three frozen cycles, then ready
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        @(posedge clk_i); #1;
        chk("memwait_stalls", 32'(stall_cnt_o), 32'd5);
        chk("memwait_back_run", 32'(state_o), 32'd1);

        // Watchdog: one request cycle plus TIMEOUT waiting cycles
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 0);
        @(posedge clk_i); #1;
        chk("timeout_state", 32'(state_o), 32'd3);
        chk("timeout_error", 32'(error_o), 32'd1);
        step(0, 1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_clears_error", 32'(error_o), 32'd0);

        // Counter saturation
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("cycle_cnt_sat", 32'(cycle_cnt_o), 32'(CMAX));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, h, b, a, y;
            r = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            a = (m_state == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            y = ($urandom_range(0, 2) == 0);
            step(r, s, h, b, a, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "bench time limit");
    end

endmodule
